// File: rtl/ltssm_pkg.sv
// Shared LTSSM definitions: substate codes, timeout defaults and the exit-code decoder.
package ltssm_pkg;

    localparam int EXIT_W = 4;
    localparam int SUB_W  = 5;

    localparam int DEF_T2MS  = 200000;
    localparam int DEF_T12MS = 1200000;
    localparam int DEF_T24MS = 2400000;
    localparam int DEF_T48MS = 4800000;
    localparam int DEF_CNT_W = 24;

    typedef enum logic [SUB_W-1:0] {
        detectQuiet          = 5'd0,
        detectActive         = 5'd1,
        pollingActive        = 5'd2,
        pollingConfiguration = 5'd3,
        cfgLinkWidthStart    = 5'd4,
        cfgLinkWidthAccept   = 5'd5,
        cfgLanenumWait       = 5'd6,
        cfgLanenumAccept     = 5'd7,
        cfgComplete          = 5'd8,
        cfgIdle              = 5'd9,
        l0                   = 5'd10
    } substate_e;

    // Codes above L0 have no defined substate; fall back to detectQuiet.
    function automatic substate_e decodeExit(input logic [EXIT_W-1:0] code);
        if (code > 4'd10) begin
            return detectQuiet;
        end
        return substate_e'({1'b0, code});
    endfunction

endpackage

// File: rtl/ltssm_timeout_timer.sv
// Per-substate timeout counter: counts up from a clear, saturates, flags limit-1.
module ltssm_timeout_timer #(
    parameter int CNT_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    input  logic [CNT_W-1:0] limit,
    output logic             expired
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (count != '1) begin
            count <= count + CNT_W'(1);
        end
    end

    // A zero limit means the substate has no timeout.
    assign expired = (limit != '0) && (count == limit - CNT_W'(1));

endmodule

// File: rtl/ltssm_substate_sequencer.sv
// LTSSM substate sequencer: merges RX/TX finish handshakes, timeouts and forceDetect into the substate code.
module ltssm_substate_sequencer
    import ltssm_pkg::*;
#(
    parameter int T2MS  = DEF_T2MS,
    parameter int T12MS = DEF_T12MS,
    parameter int T24MS = DEF_T24MS,
    parameter int T48MS = DEF_T48MS,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              rxElectricalIdle,
    input  logic              forceDetect,
    input  logic              rxFinish,
    input  logic [EXIT_W-1:0] rxExitTo,
    input  logic              txFinish,
    output logic [SUB_W-1:0]  substate,
    output logic              substateEntry,
    output logic              timeoutExit,
    output logic              linkUp
);

    substate_e         stateReg, stateNext;
    logic              rxDoneReg, rxDoneNext;
    logic              txDoneReg, txDoneNext;
    logic [EXIT_W-1:0] exitReg, exitNext;
    logic              idlePrevReg;
    logic              entryReg, entryNext;
    logic              timeoutReg, timeoutNext;
    logic              linkUpReg, linkUpNext;
    logic              timerClear;
    logic [CNT_W-1:0]  timerLimit;
    logic              expired;
    logic              rxReady, txReady;
    logic [EXIT_W-1:0] exitSel;

    always_comb begin
        unique case (stateReg)
            detectQuiet:                     timerLimit = CNT_W'(T12MS);
            pollingActive, cfgLinkWidthStart,
            cfgLinkWidthAccept, cfgLanenumAccept,
            cfgComplete:                     timerLimit = CNT_W'(T24MS);
            pollingConfiguration:            timerLimit = CNT_W'(T48MS);
            cfgLanenumWait, cfgIdle:         timerLimit = CNT_W'(T2MS);
            default:                         timerLimit = '0;
        endcase
    end

    ltssm_timeout_timer #(
        .CNT_W(CNT_W)
    ) timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timerClear),
        .limit  (timerLimit),
        .expired(expired)
    );

    // A finish pulse arriving in the same cycle counts as if its flag were already set.
    assign rxReady = rxDoneReg | rxFinish;
    assign txReady = txDoneReg | txFinish;
    assign exitSel = rxDoneReg ? exitReg : rxExitTo;

    always_comb begin
        stateNext   = stateReg;
        rxDoneNext  = rxDoneReg;
        txDoneNext  = txDoneReg;
        exitNext    = exitReg;
        entryNext   = 1'b0;
        timeoutNext = 1'b0;
        timerClear  = 1'b0;

        if (forceDetect) begin
            timerClear = 1'b1;
            if (stateReg != detectQuiet) begin
                stateNext = detectQuiet;
                entryNext = 1'b1;
            end
        end else if (stateReg == detectQuiet) begin
            if (idlePrevReg && !rxElectricalIdle) begin
                stateNext = detectActive;
                entryNext = 1'b1;
            end else if (expired) begin
                stateNext   = detectActive;
                entryNext   = 1'b1;
                timeoutNext = 1'b1;
            end
        end else if (rxReady && txReady) begin
            stateNext = decodeExit(exitSel);
            entryNext = 1'b1;
        end else if (expired) begin
            stateNext   = detectQuiet;
            entryNext   = 1'b1;
            timeoutNext = 1'b1;
        end

        if (entryNext || timerClear) begin
            timerClear = 1'b1;
            rxDoneNext = 1'b0;
            txDoneNext = 1'b0;
        end else if (stateReg != detectQuiet) begin
            if (rxFinish && !rxDoneReg) begin
                rxDoneNext = 1'b1;
                exitNext   = rxExitTo;
            end
            if (txFinish) begin
                txDoneNext = 1'b1;
            end
        end

        linkUpNext = (stateNext == l0);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stateReg    <= detectQuiet;
            rxDoneReg   <= 1'b0;
            txDoneReg   <= 1'b0;
            exitReg     <= '0;
            idlePrevReg <= 1'b0;
            entryReg    <= 1'b0;
            timeoutReg  <= 1'b0;
            linkUpReg   <= 1'b0;
        end else begin
            stateReg    <= stateNext;
            rxDoneReg   <= rxDoneNext;
            txDoneReg   <= txDoneNext;
            exitReg     <= exitNext;
            idlePrevReg <= rxElectricalIdle;
            entryReg    <= entryNext;
            timeoutReg  <= timeoutNext;
            linkUpReg   <= linkUpNext;
        end
    end

    assign substate      = stateReg;
    assign substateEntry = entryReg;
    assign timeoutExit   = timeoutReg;
    assign linkUp        = linkUpReg;

endmodule

// File: tb/tb_ltssm_substate_sequencer.sv
// Directed and randomized bench for ltssm_substate_sequencer against a cycle-level reference model.
module tb_ltssm_substate_sequencer;

    logic       clk;
    logic       reset;
    logic       rxElectricalIdle;
    logic       forceDetect;
    logic       rxFinish;
    logic [3:0] rxExitTo;
    logic       txFinish;
    logic [4:0] substate;
    logic       substateEntry;
    logic       timeoutExit;
    logic       linkUp;

    int compared   = 0;
    int mismatched = 0;
    int cycleNo    = 0;

    // Model state: substate number, cycles spent in it, and the handshake bookkeeping.
    int limTab [11] = '{10, 0, 20, 40, 20, 20, 4, 20, 20, 4, 0};
    int mState, mTicks, mExit;
    bit mRxDone, mTxDone, mEntry, mTmo, mLink, mIdlePrev;

    ltssm_substate_sequencer #(
        .T2MS (4),
        .T12MS(10),
        .T24MS(20),
        .T48MS(40),
        .CNT_W(24)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .rxElectricalIdle(rxElectricalIdle),
        .forceDetect     (forceDetect),
        .rxFinish        (rxFinish),
        .rxExitTo        (rxExitTo),
        .txFinish        (txFinish),
        .substate        (substate),
        .substateEntry   (substateEntry),
        .timeoutExit     (timeoutExit),
        .linkUp          (linkUp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("FAIL %s @cycle %0d: got %0d, expected %0d", tag, cycleNo, obs, exp);
        end
    endtask

    task automatic modelReset();
        mState = 0; mTicks = 0; mExit = 0;
        mRxDone = 0; mTxDone = 0; mEntry = 0; mTmo = 0; mLink = 0; mIdlePrev = 0;
    endtask

    task automatic modelStep(input bit idle, input bit fd, input bit rxf, input int rxe, input bit txf);
        int nxt;
        bit trans, tmo, clr, exp;
        nxt = mState; trans = 0; tmo = 0; clr = 0;
        exp = (limTab[mState] != 0) && (mTicks == limTab[mState] - 1);
        if (fd) begin
            clr = 1;
            if (mState != 0) begin trans = 1; nxt = 0; end
        end else if (mState == 0) begin
            if (mIdlePrev && !idle) begin trans = 1; nxt = 1; end
            else if (exp) begin trans = 1; nxt = 1; tmo = 1; end
        end else if ((mRxDone || rxf) && (mTxDone || txf)) begin
            trans = 1;
            nxt = mRxDone ? mExit : rxe;
            if (nxt > 10) nxt = 0;
        end else if (exp) begin
            trans = 1; nxt = 0; tmo = 1;
        end
        if (trans || clr) begin
            mTicks = 0; mRxDone = 0; mTxDone = 0;
        end else begin
            mTicks++;
            if (mState != 0) begin
                if (rxf && !mRxDone) begin mRxDone = 1; mExit = rxe; end
                if (txf) mTxDone = 1;
            end
        end
        mEntry = trans; mTmo = tmo; mState = nxt;
        mLink = (mState == 10); mIdlePrev = idle;
    endtask

    task automatic compareAll(input string tag);
        check({tag, ".substate"}, 32'(substate), 32'(mState));
        check({tag, ".entry"},    32'(substateEntry), 32'(mEntry));
        check({tag, ".timeout"},  32'(timeoutExit), 32'(mTmo));
        check({tag, ".linkUp"},   32'(linkUp), 32'(mLink));
        $display("[%0d] %s idle=%0b fd=%0b rxf=%0b rxe=%0d txf=%0b -> sub=%0d entry=%0b tmo=%0b link=%0b",
                 cycleNo, tag, rxElectricalIdle, forceDetect, rxFinish, rxExitTo, txFinish,
                 substate, substateEntry, timeoutExit, linkUp);
    endtask

    // One clock: apply inputs, advance DUT and model together, compare on the falling edge.
    task automatic step(input string tag, input bit idle, input bit fd, input bit rxf, input int rxe, input bit txf);
        rxElectricalIdle = idle;
        forceDetect      = fd;
        rxFinish         = rxf;
        rxExitTo         = 4'(rxe);
        txFinish         = txf;
        @(posedge clk);
        modelStep(idle, fd, rxf, rxe, txf);
        cycleNo++;
        @(negedge clk);
        compareAll(tag);
    endtask

    task automatic doReset(input string tag);
        reset = 1'b0;
        #1;
        check({tag, ".rstSub"},   32'(substate), 32'd0);
        check({tag, ".rstEntry"}, 32'(substateEntry), 32'd0);
        check({tag, ".rstTmo"},   32'(timeoutExit), 32'd0);
        check({tag, ".rstLink"},  32'(linkUp), 32'd0);
        modelReset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
    endtask

    // Drive any state -> detectQuiet -> detectActive -> target via one handshake.
    task automatic goTo(input int target);
        step("goto.force", 1, 1, 0, 0, 0);
        step("goto.idleFall", 0, 0, 0, 0, 0);
        step("goto.hs", 0, 0, 1, target, 1);
    endtask

    initial begin
        reset = 1'b0;
        rxElectricalIdle = 1'b1;
        forceDetect = 1'b0;
        rxFinish = 1'b0;
        rxExitTo = '0;
        txFinish = 1'b0;
        modelReset();
        #2;
        doReset("init");

        // Electrical idle falls at cycle 3 -> detectActive.
        for (int i = 0; i < 3; i++) step("idleFall", 1, 0, 0, 0, 0);
        step("idleFall", 0, 0, 0, 0, 0);
        check("idleFall.sub", 32'(substate), 32'd1);
        check("idleFall.entry", 32'(substateEntry), 32'd1);

        // detectQuiet with idle held -> 12 ms timeout to detectActive.
        step("quietTmo.force", 1, 1, 0, 0, 0);
        for (int i = 0; i < 10; i++) step("quietTmo", 1, 0, 0, 0, 0);
        check("quietTmo.sub", 32'(substate), 32'd1);
        check("quietTmo.flag", 32'(timeoutExit), 32'd1);

        // Split handshake in pollingActive, with a duplicate rxFinish that must be ignored.
        goTo(2);
        for (int c = 0; c < 7; c++) begin
            step("split", 0, 0, (c == 2) || (c == 4), (c == 2) ? 3 : 0, c == 6);
        end
        check("split.sub", 32'(substate), 32'd3);

        // Walk to L0 with simultaneous pulses, then forceDetect.
        for (int s = 4; s <= 10; s++) step("walk", 0, 0, 1, s, 1);
        check("walk.linkUp", 32'(linkUp), 32'd1);
        step("walk.force", 0, 1, 0, 0, 0);
        check("walk.linkDown", 32'(linkUp), 32'd0);

        // cfgLanenumWait 2 ms timeout, then finish on the expiry cycle.
        goTo(6);
        for (int i = 0; i < 4; i++) step("lanTmo", 0, 0, 0, 0, 0);
        check("lanTmo.sub", 32'(substate), 32'd0);
        goTo(6);
        for (int i = 0; i < 3; i++) step("lanRace", 0, 0, 0, 0, 0);
        step("lanRace", 0, 0, 1, 7, 1);
        check("lanRace.sub", 32'(substate), 32'd7);
        check("lanRace.tmo", 32'(timeoutExit), 32'd0);

        // Out-of-range exit code and same-code re-entry.
        step("exit13", 0, 0, 1, 13, 1);
        check("exit13.sub", 32'(substate), 32'd0);
        goTo(5);
        step("reenter", 0, 0, 1, 5, 1);

        // Reset mid-substate.
        goTo(8);
        step("pre.rst", 0, 0, 0, 0, 0);
        doReset("midRst");
        for (int i = 0; i < 3; i++) step("postRst", 0, 0, 0, 0, 0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            bit idle, fd, rxf, txf;
            int rxe;
            if ($urandom_range(0, 599) == 0) begin
                doReset("rndRst");
            end
            idle = ($urandom_range(0, 7) == 0) ? ~rxElectricalIdle : rxElectricalIdle;
            fd   = ($urandom_range(0, 59) == 0);
            rxf  = ($urandom_range(0, 3) == 0);
            txf  = ($urandom_range(0, 3) == 0);
            rxe  = ($urandom_range(0, 9) == 0) ? int'($urandom_range(11, 15)) : int'($urandom_range(1, 10));
            step("rnd", idle, fd, rxf, rxe, txf);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
